// File: rtl/text_shadow_ram_if.sv
// CPU write bus, video read port and clear/status lines of the text shadow RAM.
interface text_shadow_ram_if;
   logic        ce_pix;
   logic [22:0] video_addr;
   logic [7:0]  video_data;
   logic        cpu_we;
   logic [22:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic        shadow_en;
   logic        cpu_ready;
   logic        clr_start;
   logic        clear_busy;
   logic        q_ovf;

   modport slave (
      input  ce_pix, video_addr, cpu_we, cpu_addr, cpu_din, shadow_en, clr_start,
      output video_data, cpu_ready, clear_busy, q_ovf
   );

   modport master (
      output ce_pix, video_addr, cpu_we, cpu_addr, cpu_din, shadow_en, clr_start,
      input  video_data, cpu_ready, clear_busy, q_ovf
   );
endinterface

// File: rtl/text_shadow_ram.sv
// Shadow copy of the text page: queued CPU writes, pixel-cycle video reads with
// write forwarding, and a block-clear engine sharing one single-port byte RAM.
module text_shadow_ram #(
   parameter logic [22:0] WIN_BASE  = 23'h000400,
   parameter int          AW        = 11,
   parameter int          QDEPTH    = 4,
   parameter logic [7:0]  CLEAR_VAL = 8'hA0
) (
   input logic               clk,
   input logic               reset_n,
   text_shadow_ram_if.slave  bus
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
   typedef struct packed {
      logic [AW-1:0] idx;
      logic [7:0]    dat;
   } entry_t;

   state_t        state_q, state_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;
   logic          clr_pend_q, clr_pend_d;
   logic          q_ovf_q, q_ovf_d;
   logic [7:0]    video_data_q, video_data_d;

   entry_t        queue [QDEPTH];
   logic [7:0]    mem [2**AW];

   logic [22:0]   cpu_off, vid_off;
   logic          cpu_in_win, vid_in_win;
   logic          busy, ready, push, pop, clr_wr, fwd_hit;
   logic [7:0]    fwd_dat;

   // Subtraction wraps, so addresses below the base land far outside the window.
   assign cpu_off    = bus.cpu_addr - WIN_BASE;
   assign vid_off    = bus.video_addr - WIN_BASE;
   assign cpu_in_win = (cpu_off >> AW) == '0;
   assign vid_in_win = (vid_off >> AW) == '0;

   assign busy   = (state_q == CLEAR) || clr_pend_q;
   assign ready  = (count_q < CW'(QDEPTH)) && !busy;
   assign push   = bus.cpu_we && ready && bus.shadow_en && cpu_in_win;
   assign pop    = !bus.ce_pix && (count_q != '0) && (state_q != CLEAR);
   assign clr_wr = (state_q == CLEAR) && !bus.ce_pix;

   // Scan oldest to newest so the newest matching entry wins.
   always_comb begin
      fwd_hit = 1'b0;
      fwd_dat = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         if ((CW'(i) < count_q) &&
             (queue[PW'(rd_ptr_q + PW'(i))].idx == vid_off[AW-1:0])) begin
            fwd_hit = 1'b1;
            fwd_dat = queue[PW'(rd_ptr_q + PW'(i))].dat;
         end
      end
   end

   always_comb begin
      video_data_d = video_data_q;
      if (bus.ce_pix) begin
         if (!vid_in_win)  video_data_d = '0;
         else if (busy)    video_data_d = CLEAR_VAL;
         else if (fwd_hit) video_data_d = fwd_dat;
         else              video_data_d = mem[vid_off[AW-1:0]];
      end

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      q_ovf_d  = q_ovf_q | (bus.cpu_we & ~ready);

      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_pend_d = 1'b0;
      case (state_q)
         CLEAR: begin
            if (clr_wr) begin
               clr_addr_d = clr_addr_q + 1'b1;
               if (&clr_addr_q) state_d = IDLE;
            end
         end
         default: begin
            // A clear request waits (as busy) until every queued write has landed.
            if (count_d != '0) begin
               state_d    = DRAIN;
               clr_pend_d = clr_pend_q | bus.clr_start;
            end else if (clr_pend_q || bus.clr_start) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         clr_addr_q   <= '0;
         clr_pend_q   <= 1'b0;
         q_ovf_q      <= 1'b0;
         video_data_q <= '0;
      end else begin
         state_q      <= state_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         clr_addr_q   <= clr_addr_d;
         clr_pend_q   <= clr_pend_d;
         q_ovf_q      <= q_ovf_d;
         video_data_q <= video_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) queue[wr_ptr_q] <= '{idx: cpu_off[AW-1:0], dat: bus.cpu_din};
   end

   // Single RAM port: drain and clear only ever write on non-pixel cycles.
   always_ff @(posedge clk) begin
      if (pop)         mem[queue[rd_ptr_q].idx] <= queue[rd_ptr_q].dat;
      else if (clr_wr) mem[clr_addr_q]          <= CLEAR_VAL;
   end

   assign bus.video_data = video_data_q;
   assign bus.cpu_ready  = ready;
   assign bus.clear_busy = busy;
   assign bus.q_ovf      = q_ovf_q;
endmodule

// File: tb/tb_text_shadow_ram.sv
// Random and directed bench for text_shadow_ram, checked every cycle against a
// queue/array model of the text page.
module tb_text_shadow_ram;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   text_shadow_ram_if bus();

   text_shadow_ram dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct { logic [10:0] idx; logic [7:0] dat; } ent_t;

   logic [7:0]  m_ram [2048];
   bit          m_known [2048];
   ent_t        m_q [$];
   bit          m_clr, m_pend, m_ovf, m_vknown;
   int          m_cptr;
   logic [7:0]  m_vid;

   bit          md_busy, md_ready, md_start, md_push, md_found;
   ent_t        md_e, md_p;
   logic [10:0] md_vidx;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic bit in_win(input logic [22:0] a);
      logic [22:0] off;
      off = a - 23'h000400;
      return off < 23'd2048;
   endfunction

   // Reference model: the page as a byte array, pending writes as a FIFO queue.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q.delete();
         m_clr = 0; m_pend = 0; m_ovf = 0; m_cptr = 0;
         m_vid = 8'h00; m_vknown = 1;
      end else begin
         md_busy  = m_clr || m_pend;
         md_ready = (m_q.size() < 4) && !md_busy;
         md_start = bus.clr_start && !m_clr;
         if (bus.ce_pix) begin
            md_vidx = 11'(bus.video_addr - 23'h000400);
            if (!in_win(bus.video_addr)) begin
               m_vid = 8'h00; m_vknown = 1;
            end else if (md_busy) begin
               m_vid = 8'hA0; m_vknown = 1;
            end else begin
               md_found = 0;
               foreach (m_q[i]) if (m_q[i].idx == md_vidx) begin
                  m_vid = m_q[i].dat; md_found = 1;
               end
               if (md_found) m_vknown = 1;
               else begin
                  m_vid = m_ram[md_vidx]; m_vknown = m_known[md_vidx];
               end
            end
         end
         md_push = 0;
         if (bus.cpu_we) begin
            if (!md_ready) m_ovf = 1;
            else if (bus.shadow_en && in_win(bus.cpu_addr)) begin
               md_push = 1;
               md_e.idx = 11'(bus.cpu_addr - 23'h000400);
               md_e.dat = bus.cpu_din;
            end
         end
         if (!bus.ce_pix && !m_clr && m_q.size() > 0) begin
            md_p = m_q.pop_front();
            m_ram[md_p.idx] = md_p.dat; m_known[md_p.idx] = 1;
         end
         if (m_clr && !bus.ce_pix) begin
            m_ram[m_cptr] = 8'hA0; m_known[m_cptr] = 1;
            if (m_cptr == 2047) m_clr = 0;
            else m_cptr++;
         end
         if (md_push) m_q.push_back(md_e);
         if ((m_pend || md_start) && m_q.size() == 0) begin
            m_clr = 1; m_cptr = 0; m_pend = 0;
         end else if (md_start) m_pend = 1;
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         check("cpu_ready", bus.cpu_ready, 32'((m_q.size() < 4) && !(m_clr || m_pend)));
         check("clear_busy", bus.clear_busy, 32'(m_clr || m_pend));
         check("q_ovf", bus.q_ovf, 32'(m_ovf));
         if (m_vknown) check("video_data", bus.video_data, m_vid);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [22:0] a, input logic [7:0] d);
      bus.cpu_we = 1; bus.cpu_addr = a; bus.cpu_din = d;
      tick();
      bus.cpu_we = 0;
   endtask

   task automatic rd(input logic [22:0] a, input logic [7:0] exp, input string nm);
      bus.ce_pix = 1; bus.video_addr = a;
      tick();
      check(nm, bus.video_data, exp);
   endtask

   task automatic rand_addr(output logic [22:0] a);
      case ($urandom_range(0, 15))
         0:       a = 23'h0003FF;
         1:       a = 23'h000C00;
         2:       a = 23'h7FFFFF;
         default: a = 23'h000400 + 23'($urandom_range(0, 15));
      endcase
   endtask

   initial begin
      int n;
      logic [22:0] a;
      bus.ce_pix = 0; bus.video_addr = '0; bus.cpu_we = 0; bus.cpu_addr = '0;
      bus.cpu_din = '0; bus.shadow_en = 1; bus.clr_start = 0;
      repeat (2) tick();
      reset_n = 1;

      wr(23'h000400, 8'hC1);
      tick(); tick();
      rd(23'h000400, 8'hC1, "basic_read");
      check("model_basic", m_vid, 8'hC1);

      bus.ce_pix = 1; bus.video_addr = 23'h000401;
      wr(23'h000401, 8'h11); wr(23'h000401, 8'h22);
      wr(23'h000402, 8'h33); wr(23'h000403, 8'h44);
      check("ready_full", bus.cpu_ready, 0);
      tick();
      check("fwd_newest", bus.video_data, 8'h22);
      wr(23'h000404, 8'h55);
      check("ovf_set", bus.q_ovf, 1);
      bus.ce_pix = 0;
      repeat (4) tick();
      check("model_drained", m_q.size(), 0);
      check("ready_drained", bus.cpu_ready, 1);
      rd(23'h000401, 8'h22, "ram_401");
      rd(23'h000402, 8'h33, "ram_402");
      bus.ce_pix = 0;

      #2 reset_n = 0;
      #1;
      check("rst_ready", bus.cpu_ready, 1);
      check("rst_video", bus.video_data, 8'h00);
      check("rst_busy", bus.clear_busy, 0);
      check("rst_ovf", bus.q_ovf, 0);
      tick(); reset_n = 1;

      wr(23'h0003FF, 8'h55); wr(23'h000C00, 8'h66);
      check("win_model_empty", m_q.size(), 0);
      rd(23'h000400, 8'hC1, "win_ref");
      rd(23'h0003FF, 8'h00, "win_below");
      rd(23'h000401, 8'h22, "win_ref2");
      rd(23'h000C00, 8'h00, "win_above");
      bus.ce_pix = 0;

      bus.clr_start = 1; tick(); bus.clr_start = 0;
      n = 0;
      while (bus.clear_busy && n < 10000) begin n++; tick(); end
      check("clear_cycles", n, 2048);
      rd(23'h000400, 8'hA0, "clr_400");
      rd(23'h000401, 8'hA0, "clr_401");
      rd(23'h000BFF, 8'hA0, "clr_bff");
      bus.ce_pix = 0;

      bus.shadow_en = 0; wr(23'h000500, 8'h77); repeat (3) tick(); bus.shadow_en = 1;
      rd(23'h000500, 8'hA0, "shadow_off");

      bus.ce_pix = 1; bus.video_addr = 23'h000000;
      wr(23'h000410, 8'h01); wr(23'h000411, 8'h02);
      bus.ce_pix = 0;
      wr(23'h000410, 8'h03);
      check("simul_model_cnt", m_q.size(), 2);
      rd(23'h000410, 8'h03, "simul_fwd");
      bus.ce_pix = 0; repeat (3) tick();
      rd(23'h000410, 8'h03, "simul_410");
      rd(23'h000411, 8'h02, "simul_411");
      bus.ce_pix = 0;

      for (int i = 0; i < 3000; i++) begin
         bus.ce_pix = ($urandom_range(0, 2) != 0);
         bus.cpu_we = $urandom_range(0, 1);
         rand_addr(a); bus.cpu_addr = a;
         rand_addr(a); bus.video_addr = a;
         bus.cpu_din = 8'($urandom);
         bus.shadow_en = ($urandom_range(0, 7) != 0);
         bus.clr_start = ($urandom_range(0, 999) == 0);
         tick();
      end
      bus.cpu_we = 0; bus.clr_start = 0; bus.ce_pix = 0; bus.shadow_en = 1;
      n = 0;
      while (bus.clear_busy && n < 5000) begin n++; tick(); end
      repeat (6) tick();
      check("idle_before_toggle", bus.clear_busy, 0);

      bus.clr_start = 1; tick(); bus.clr_start = 0;
      bus.ce_pix = 1;
      n = 0;
      while (bus.clear_busy && n < 10000) begin n++; tick(); bus.ce_pix = ~bus.ce_pix; end
      check("clear_cycles_toggle", n, 4096);
      bus.ce_pix = 0;
      rd(23'h000407, 8'hA0, "clr2_407");
      bus.ce_pix = 0;

      bus.clr_start = 1; tick(); bus.clr_start = 0;
      repeat (100) tick();
      check("midclr_busy", bus.clear_busy, 1);
      #2 reset_n = 0;
      #1;
      check("midclr_rst_busy", bus.clear_busy, 0);
      check("midclr_rst_ready", bus.cpu_ready, 1);
      tick(); reset_n = 1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
